// File: rtl/gshare_pht.sv
// Dual-lookup gshare pattern history table with 2-bit saturating counters.
// Define PHT_BYPASS_EN so that a lookup sees same-cycle updates to its index.
module gshare_pht #(
    parameter int PC_W  = 32,
    parameter int GHR_W = 5,
    parameter int IDX_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [GHR_W-1:0] ghr,
    input  logic [PC_W-1:0]  pc1,
    input  logic [PC_W-1:0]  pc2,
    input  logic             upd_valid1,
    input  logic             upd_valid2,
    input  logic [IDX_W-1:0] upd_idx1,
    input  logic [IDX_W-1:0] upd_idx2,
    input  logic             upd_taken1,
    input  logic             upd_taken2,
    output logic             pred_taken1,
    output logic             pred_taken2,
    output logic [IDX_W-1:0] pred_idx1,
    output logic [IDX_W-1:0] pred_idx2
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       counters      [ENTRIES];
    logic [1:0]       next_counters [ENTRIES];
    logic [IDX_W-1:0] idx1;
    logic [IDX_W-1:0] idx2;
    logic             lookup1;
    logic             lookup2;
    logic             unused_pc_bits;

    assign idx1 = pc1[IDX_W+1:2] ^ IDX_W'(ghr);
    assign idx2 = pc2[IDX_W+1:2] ^ IDX_W'(ghr);

    assign unused_pc_bits = ^{pc1[PC_W-1:IDX_W+2], pc1[1:0],
                              pc2[PC_W-1:IDX_W+2], pc2[1:0]};

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] result;
        result = cnt;
        if (taken && cnt != 2'b11) begin
            result = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            result = cnt - 2'b01;
        end
        return result;
    endfunction

    // Slot 2 sees slot 1's result so same-index updates chain in order.
    always_comb begin
        next_counters = counters;
        if (upd_valid1) begin
            next_counters[upd_idx1] = sat_step(next_counters[upd_idx1], upd_taken1);
        end
        if (upd_valid2) begin
            next_counters[upd_idx2] = sat_step(next_counters[upd_idx2], upd_taken2);
        end
    end

`ifdef PHT_BYPASS_EN
    assign lookup1 = next_counters[idx1][1];
    assign lookup2 = next_counters[idx2][1];
`else
    assign lookup1 = counters[idx1][1];
    assign lookup2 = counters[idx2][1];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters[i] <= 2'b01;
            end
        end else begin
            counters <= next_counters;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pred_taken1 <= 1'b0;
            pred_taken2 <= 1'b0;
            pred_idx1   <= '0;
            pred_idx2   <= '0;
        end else if (!stall) begin
            pred_taken1 <= lookup1;
            pred_taken2 <= lookup2;
            pred_idx1   <= idx1;
            pred_idx2   <= idx2;
        end
    end

endmodule

// File: tb/tb_gshare_pht.sv
// Randomized and directed bench for gshare_pht against a counter-array model.
// Honours PHT_BYPASS_EN the same way as the design.
module tb_gshare_pht;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [4:0]  ghr;
    logic [31:0] pc1, pc2;
    logic        upd_valid1, upd_valid2;
    logic [4:0]  upd_idx1, upd_idx2;
    logic        upd_taken1, upd_taken2;
    logic        pred_taken1, pred_taken2;
    logic [4:0]  pred_idx1, pred_idx2;

    int model [32];
    int exp_taken1, exp_taken2, exp_idx1, exp_idx2;
    int num_checks = 0;
    int num_fail   = 0;

    gshare_pht #(.PC_W(32), .GHR_W(5), .IDX_W(5)) dut (
        .clock(clock), .reset(reset), .stall(stall), .ghr(ghr),
        .pc1(pc1), .pc2(pc2),
        .upd_valid1(upd_valid1), .upd_valid2(upd_valid2),
        .upd_idx1(upd_idx1), .upd_idx2(upd_idx2),
        .upd_taken1(upd_taken1), .upd_taken2(upd_taken2),
        .pred_taken1(pred_taken1), .pred_taken2(pred_taken2),
        .pred_idx1(pred_idx1), .pred_idx2(pred_idx2)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        num_checks++;
        if (observed != expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int model_step(input int cnt, input logic taken);
        if (taken) return (cnt < 3) ? cnt + 1 : 3;
        return (cnt > 0) ? cnt - 1 : 0;
    endfunction

    function automatic int hash(input logic [31:0] pc, input logic [4:0] h);
        return ((pc >> 2) ^ h) % 32;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 1;
        exp_taken1 = 0; exp_taken2 = 0; exp_idx1 = 0; exp_idx2 = 0;
    endtask

    // Drive one cycle, advance the model, then compare all four outputs.
    task automatic applyStimulus(input logic s, input logic [4:0] g,
                                 input logic [31:0] p1, input logic [31:0] p2,
                                 input logic v1, input logic [4:0] i1, input logic t1,
                                 input logic v2, input logic [4:0] i2, input logic t2);
        int h1, h2;
        @(negedge clock);
        stall = s; ghr = g; pc1 = p1; pc2 = p2;
        upd_valid1 = v1; upd_idx1 = i1; upd_taken1 = t1;
        upd_valid2 = v2; upd_idx2 = i2; upd_taken2 = t2;
        h1 = hash(p1, g);
        h2 = hash(p2, g);
`ifndef PHT_BYPASS_EN
        if (!s) begin
            exp_taken1 = (model[h1] >= 2); exp_taken2 = (model[h2] >= 2);
            exp_idx1 = h1; exp_idx2 = h2;
        end
`endif
        if (v1) model[i1] = model_step(model[i1], t1);
        if (v2) model[i2] = model_step(model[i2], t2);
`ifdef PHT_BYPASS_EN
        if (!s) begin
            exp_taken1 = (model[h1] >= 2); exp_taken2 = (model[h2] >= 2);
            exp_idx1 = h1; exp_idx2 = h2;
        end
`endif
        @(posedge clock);
        #1;
        checkOutput("pred_taken1", int'(pred_taken1), exp_taken1);
        checkOutput("pred_taken2", int'(pred_taken2), exp_taken2);
        checkOutput("pred_idx1", int'(pred_idx1), exp_idx1);
        checkOutput("pred_idx2", int'(pred_idx2), exp_idx2);
    endtask

    task automatic idle_lookup(input logic [4:0] g, input logic [31:0] p1, input logic [31:0] p2);
        applyStimulus(1'b0, g, p1, p2, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; ghr = '0; pc1 = '0; pc2 = '0;
        upd_valid1 = 1'b0; upd_valid2 = 1'b0; upd_idx1 = '0; upd_idx2 = '0;
        upd_taken1 = 1'b0; upd_taken2 = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_taken1", int'(pred_taken1), 0);
        checkOutput("reset_idx2", int'(pred_idx2), 0);
        checkOutput("reset_counter", int'(dut.counters[7]), 1);
        @(negedge clock);
        reset = 1'b0;

        idle_lookup(5'd0, 32'h00, 32'h7C);
        checkOutput("first_idx2_31", int'(pred_idx2), 31);

        repeat (3) applyStimulus(1'b0, 5'd0, 32'h40, 32'h44, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        idle_lookup(5'd0, 32'h14, 32'h18);
        checkOutput("idx5_taken", int'(pred_taken1), 1);
        checkOutput("idx5_counter_11", int'(dut.counters[5]), 3);

        repeat (5) applyStimulus(1'b0, 5'd0, 32'h40, 32'h44, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("idx5_counter_00", int'(dut.counters[5]), 0);
        idle_lookup(5'd0, 32'h14, 32'h18);
        checkOutput("idx5_not_taken", int'(pred_taken1), 0);

        applyStimulus(1'b0, 5'd0, 32'h0, 32'h4, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1);
        checkOutput("dual_tt_11", int'(dut.counters[9]), 3);
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h4, 1'b1, 5'd10, 1'b1, 1'b1, 5'd10, 1'b0);
        checkOutput("dual_tn_01", int'(dut.counters[10]), 1);
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h4, 1'b1, 5'd11, 1'b0, 1'b1, 5'd11, 1'b0);
        checkOutput("dual_nn_00", int'(dut.counters[11]), 0);

        applyStimulus(1'b0, 5'd0, 32'h0C, 32'h0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
`ifdef PHT_BYPASS_EN
        checkOutput("bypass_taken", int'(pred_taken1), 1);
`else
        checkOutput("nobypass_taken", int'(pred_taken1), 0);
`endif
        idle_lookup(5'd0, 32'h0C, 32'h0);
        checkOutput("after_update_taken", int'(pred_taken1), 1);

        idle_lookup(5'h1F, 32'h0C, 32'h0);
        checkOutput("hash_idx_1c", int'(pred_idx1), 28);
        applyStimulus(1'b1, 5'h1F, 32'h50, 32'h8, 1'b1, 5'd20, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("stall_hold_idx", int'(pred_idx1), 28);
        checkOutput("stall_update", int'(dut.counters[20]), 2);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 3) == 0), 5'($urandom), $urandom, $urandom,
                          1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                          1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
        end

        // Reset lands between the update being driven and its clock edge.
        @(negedge clock);
        upd_valid1 = 1'b1; upd_idx1 = 5'd2; upd_taken1 = 1'b1;
        upd_valid2 = 1'b1; upd_idx2 = 5'd6; upd_taken2 = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        checkOutput("midreset_taken2", int'(pred_taken2), 0);
        checkOutput("midreset_cnt2", int'(dut.counters[2]), 1);
        checkOutput("midreset_cnt6", int'(dut.counters[6]), 1);
        @(negedge clock);
        upd_valid1 = 1'b0; upd_valid2 = 1'b0;
        reset = 1'b0;
        for (int n = 0; n < 50; n++) begin
            applyStimulus(1'b0, 5'($urandom), $urandom, $urandom,
                          1'($urandom), 5'($urandom), 1'($urandom),
                          1'($urandom), 5'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Dual-lookup gshare pattern history table (PHT) in the fetch stage of the superscalar out-of-order core.
- Consumes the registered global history register value and two fetch PCs, and produces registered taken/not-taken predictions for both fetch slots.
- Also returns the PHT index used for each prediction, which travels down the pipe and comes back on the execute-stage update ports, where resolved branches train the 2-bit saturating counters.

Parameters:
- PC_W, 32, fetch PC width.
- GHR_W, 5, global history width.
- IDX_W, 5, PHT index width; entries = 2**IDX_W; must satisfy IDX_W >= GHR_W.

Ports:
- clock  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  fetch stall; holds lookup outputs.
- ghr  input  GHR_W  global history from the GHR block, already registered.
- pc1  input  PC_W  fetch slot 1 PC.
- pc2  input  PC_W  fetch slot 2 PC.
- upd_valid1  input  1  slot 1 resolved conditional branch.
- upd_valid2  input  1  slot 2 resolved conditional branch.
- upd_idx1  input  IDX_W  PHT index returned with slot 1.
- upd_idx2  input  IDX_W  PHT index returned with slot 2.
- upd_taken1  input  1  actual outcome, slot 1.
- upd_taken2  input  1  actual outcome, slot 2.
- pred_taken1  output  1  registered prediction, slot 1.
- pred_taken2  output  1  registered prediction, slot 2.
- pred_idx1  output  IDX_W  registered index, slot 1.
- pred_idx2  output  IDX_W  registered index, slot 2.

Behaviour:
- Index computation:
  - idxN = pcN[IDX_W+1:2] XOR {zeros(IDX_W-GHR_W), ghr}.
  - ghr is zero-extended at the MSB side.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = counter[1].
- Lookup latency: one cycle. On a clock edge with stall=0, pred_takenN <= counter[idxN][1] and pred_idxN <= idxN.
- Stall: with stall=1, pred_* hold their values. Updates still apply.
- Updates:
  - On each edge, a counter at a valid upd_idxN increments if taken and decrements if not.
  - Counters saturate at 11 and 00; there is no wrap.
  - Updates are independent of stall.
- Simultaneous updates to the same index: applied in order, slot 1 then slot 2. Examples from 01:
  - taken, taken -> 11
  - taken, NT -> 01
  - NT, NT -> 00
- Different indices: both updates are applied independently in the same cycle.
- Lookup and update on the same index in the same cycle: behaviour is set by PHT_BYPASS_EN (see Optional Feature).
- pc1 and pc2 may map to the same index; both slots then return the same prediction.
- Reset (asynchronous):
  - All counters -> 01.
  - pred_taken1/2 -> 0; pred_idx1/2 -> 0.
  - Reset asserted mid-operation discards any in-flight update.
- Storage is a flop array; there is no SRAM read latency.

Optional Feature:
- Macro: PHT_BYPASS_EN.
- Defined: a lookup whose index matches a same-cycle valid update sees the post-update counter value, including the chained two-update result.
- Undefined: the lookup sees the pre-update array value. The update still lands in the array at the same edge.

Test Plan:
- Reset, then look up pc1=0x00, pc2=0x7C with ghr=0 -> pred_taken1=0, pred_taken2=0, pred_idx1=0, pred_idx2=31.
- Apply 3 taken updates to idx 5, then look up pc1=0x14 with ghr=0 -> pred_taken1=1; an internal probe reads the counter at 11.
- Apply 4 NT updates to idx 5 from 11, then 1 more NT -> counter 00 (no wrap); a subsequent lookup gives 0.
- Same-cycle upd_valid1=upd_valid2=1, both idx 9, taken/taken, from 01 -> counter 11. Repeat with taken/NT -> 01.
- With PHT_BYPASS_EN defined: counter at idx 3 = 01; in the same cycle apply update idx 3 taken and look up pc1=0x0C, ghr=0 -> pred_taken1=1. With the macro undefined -> pred_taken1=0, and the next lookup gives 1.
- Hashing and stall:
  - ghr=0x1F with pc1=0x0C -> pred_idx1=0x1C.
  - Assert stall and change pc1 -> pred_idx1 holds 0x1C.
  - An update issued during the stall still applies.
